// File: rtl/axis2fib_txctrl_gen_if.sv
// AXI-Stream slave bundle feeding the bridge TX control block.
// The master modport belongs to the frame source; the slave modport to the TX control.
interface axis2fib_txctrl_gen_if #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH/8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tlast;
  logic                  tuser;
  logic                  tready;

  modport master (
    output tdata, tkeep, tvalid, tlast, tuser,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tvalid, tlast, tuser,
    output tready
  );
endinterface

// File: rtl/axis2fib_txctrl_gen.sv
// AXI-Stream to bridge TX FIFO control. Streams frame beats into the TX data FIFO
// with one cycle of latency and, after each frame, writes a status word
// (byte count plus oversize / keep / tuser error flags) into the byte-count FIFO.
// tready is registered; the almost-full margin absorbs its one-cycle lag.
module axis2fib_txctrl_gen #(
  parameter int DATA_WIDTH      = 64,
  parameter int KEEP_WIDTH      = DATA_WIDTH/8,
  parameter int DATA_PTR        = 8,
  parameter int DATA_DEPTH      = 512,
  parameter int AFULL_MARGIN    = 4,
  parameter int BCNT_WIDTH      = 32,
  parameter int MAX_FRAME_BYTES = 1518
) (
  input  logic                  clk,
  input  logic                  reset,
  axis2fib_txctrl_gen_if.slave  s_axis,
  output logic [DATA_WIDTH-1:0] wr2_txdata_fifo,
  output logic                  txdata_wrreq,
  input  logic                  txdata_wrfull,
  input  logic [DATA_PTR:0]     txdata_wrusedw,
  output logic [BCNT_WIDTH-1:0] wr2_txwbcnt_fifo,
  output logic                  txwbcnt_wrreq,
  input  logic                  txwbcnt_wrfull,
  output logic                  bcnt_more_than_max,
  output logic [15:0]           frame_cnt,
  output logic [2:0]            axis_wr_state
);

  localparam int PW = $clog2(KEEP_WIDTH + 1);
  localparam logic [DATA_PTR+1:0] DEPTH_L = (DATA_PTR+2)'(DATA_DEPTH);
  localparam logic [DATA_PTR+1:0] AFULL_L = (DATA_PTR+2)'(AFULL_MARGIN);
  localparam logic [16:0]         MAX_L   = 17'(MAX_FRAME_BYTES);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    DATA = 3'b010,
    STAT = 3'b100
  } state_t;

  // Number of enabled bytes in a beat.
  function automatic logic [PW-1:0] popcount(input logic [KEEP_WIDTH-1:0] k);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) c = c + PW'(k[i]);
    return c;
  endfunction

  // Byte counter add that sticks at 16'hFFFF instead of wrapping.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [PW-1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  state_t                  state_p1;
  logic                    tready_p1;
  logic                    vld_p1;
  logic [DATA_WIDTH-1:0]   data_p1;
  logic [15:0]             bcnt_p1;
  logic                    oversize_p1;
  logic                    keep_err_p1;
  logic                    tuser_err_p1;
  logic                    stat_vld_p1;
  logic [BCNT_WIDTH-1:0]   stat_p1;
  logic [15:0]             frame_cnt_p1;

  logic                    accept_p0;
  logic [PW-1:0]           pop_p0;
  logic [16:0]             sum_p0;
  logic [KEEP_WIDTH-1:0]   keep_inc_p0;
  logic                    keep_bad_p0;
  logic [DATA_PTR+1:0]     free_p0;
  logic                    space_ok_p0;
  logic [BCNT_WIDTH-1:0]   status_p0;

  // ---- stage p0: beat qualification, byte accounting, FIFO space ----
  assign accept_p0   = s_axis.tvalid && tready_p1;
  assign pop_p0      = popcount(s_axis.tkeep);
  assign sum_p0      = {1'b0, bcnt_p1} + 17'(pop_p0);
  assign keep_inc_p0 = s_axis.tkeep + KEEP_WIDTH'(1);
  assign keep_bad_p0 = (s_axis.tkeep == '0) ||
                       (!s_axis.tlast && (s_axis.tkeep != '1)) ||
                       (s_axis.tlast && ((s_axis.tkeep & keep_inc_p0) != '0));
  assign free_p0     = DEPTH_L - {1'b0, txdata_wrusedw};
  assign space_ok_p0 = !txdata_wrfull && (free_p0 > AFULL_L);

  // Assemble the status word from the accumulated frame state; unused upper bits stay zero.
  always_comb begin
    status_p0        = '0;
    status_p0[15:0]  = bcnt_p1;
    status_p0[16]    = oversize_p1;
    status_p0[17]    = keep_err_p1;
    status_p0[18]    = tuser_err_p1;
  end

  // ---- stage p1: frame FSM, data write strobe, status write ----
  // A reset mid-frame drops the partial frame: counters and flags restart and no status is written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p1     <= IDLE;
      tready_p1    <= 1'b0;
      vld_p1       <= 1'b0;
      data_p1      <= '0;
      bcnt_p1      <= '0;
      oversize_p1  <= 1'b0;
      keep_err_p1  <= 1'b0;
      tuser_err_p1 <= 1'b0;
      stat_vld_p1  <= 1'b0;
      stat_p1      <= '0;
      frame_cnt_p1 <= '0;
    end else begin
      vld_p1      <= accept_p0;
      stat_vld_p1 <= 1'b0;
      if (accept_p0) data_p1 <= s_axis.tdata;
      case (state_p1)
        IDLE: begin
          tready_p1 <= 1'b0;
          // Some FIFO IPs hold full high while in reset; wait for it to clear.
          if (!txdata_wrfull) begin
            state_p1     <= DATA;
            bcnt_p1      <= '0;
            oversize_p1  <= 1'b0;
            keep_err_p1  <= 1'b0;
            tuser_err_p1 <= 1'b0;
          end
        end
        DATA: begin
          tready_p1 <= space_ok_p0 && !(accept_p0 && s_axis.tlast);
          if (accept_p0) begin
            bcnt_p1 <= sat_add16(bcnt_p1, pop_p0);
            if (sum_p0 > MAX_L) oversize_p1  <= 1'b1;
            if (keep_bad_p0)    keep_err_p1  <= 1'b1;
            if (s_axis.tuser)   tuser_err_p1 <= 1'b1;
            if (s_axis.tlast)   state_p1     <= STAT;
          end
        end
        STAT: begin
          tready_p1 <= 1'b0;
          if (!txwbcnt_wrfull) begin
            stat_vld_p1  <= 1'b1;
            stat_p1      <= status_p0;
            frame_cnt_p1 <= frame_cnt_p1 + 16'd1;
            bcnt_p1      <= '0;
            oversize_p1  <= 1'b0;
            keep_err_p1  <= 1'b0;
            tuser_err_p1 <= 1'b0;
            state_p1     <= DATA;
          end
        end
        default: begin
          state_p1  <= IDLE;
          tready_p1 <= 1'b0;
        end
      endcase
    end
  end

  assign s_axis.tready      = tready_p1;
  assign wr2_txdata_fifo    = data_p1;
  assign txdata_wrreq       = vld_p1;
  assign wr2_txwbcnt_fifo   = stat_p1;
  assign txwbcnt_wrreq      = stat_vld_p1;
  assign bcnt_more_than_max = oversize_p1;
  assign frame_cnt          = frame_cnt_p1;
  assign axis_wr_state      = state_p1;

endmodule

// File: tb/tb_axis2fib_txctrl_gen.sv
// Bench for axis2fib_txctrl_gen: directed frames, back-pressure and reset cases on a
// 64-bit instance (frame limit 64 bytes), random frames against a frame-level
// reference model, and a single-beat frame on a 128-bit instance.
module tb_axis2fib_txctrl_gen;
  localparam int MAXB  = 64;
  localparam int BOUND = 200;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // 64-bit instance
  axis2fib_txctrl_gen_if #(.DATA_WIDTH(64)) s0 ();
  logic [63:0] wr2_txdata_fifo;
  logic        txdata_wrreq;
  logic        txdata_wrfull;
  logic [8:0]  txdata_wrusedw;
  logic [31:0] wr2_txwbcnt_fifo;
  logic        txwbcnt_wrreq;
  logic        txwbcnt_wrfull;
  logic        bcnt_more_than_max;
  logic [15:0] frame_cnt;
  logic [2:0]  axis_wr_state;

  axis2fib_txctrl_gen #(.DATA_WIDTH(64), .MAX_FRAME_BYTES(MAXB)) dut0 (
    .clk(clk), .reset(reset), .s_axis(s0),
    .wr2_txdata_fifo(wr2_txdata_fifo), .txdata_wrreq(txdata_wrreq),
    .txdata_wrfull(txdata_wrfull), .txdata_wrusedw(txdata_wrusedw),
    .wr2_txwbcnt_fifo(wr2_txwbcnt_fifo), .txwbcnt_wrreq(txwbcnt_wrreq),
    .txwbcnt_wrfull(txwbcnt_wrfull), .bcnt_more_than_max(bcnt_more_than_max),
    .frame_cnt(frame_cnt), .axis_wr_state(axis_wr_state)
  );

  // 128-bit instance
  axis2fib_txctrl_gen_if #(.DATA_WIDTH(128)) s1 ();
  logic [127:0] d1_wdata;
  logic         d1_wrreq;
  logic         d1_wrfull;
  logic [8:0]   d1_usedw;
  logic [31:0]  d1_stat;
  logic         d1_statreq;
  logic         d1_statfull;
  logic         d1_ovs;
  logic [15:0]  d1_fc;
  logic [2:0]   d1_state;

  axis2fib_txctrl_gen #(.DATA_WIDTH(128)) dut1 (
    .clk(clk), .reset(reset), .s_axis(s1),
    .wr2_txdata_fifo(d1_wdata), .txdata_wrreq(d1_wrreq),
    .txdata_wrfull(d1_wrfull), .txdata_wrusedw(d1_usedw),
    .wr2_txwbcnt_fifo(d1_stat), .txwbcnt_wrreq(d1_statreq),
    .txwbcnt_wrfull(d1_statfull), .bcnt_more_than_max(d1_ovs),
    .frame_cnt(d1_fc), .axis_wr_state(d1_state)
  );

  int          errors = 0;
  int          checks = 0;
  int          stat_writes = 0;
  logic [15:0] exp_fc = 16'd0;
  logic [63:0] exp_data[$];
  logic [31:0] exp_stat[$];
  logic [63:0] mon_d;
  logic [31:0] mon_s;

  logic [63:0] fr_data[0:15];
  logic [7:0]  fr_keep[0:15];
  logic        fr_user[0:15];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame-level reference: byte total, error rules and oversize from the whole beat list.
  function automatic logic [31:0] model_status(input int n);
    int   sum;
    bit   ke, ue, contig;
    logic [15:0] bc;
    sum = 0; ke = 0; ue = 0;
    for (int i = 0; i < n; i++) begin
      sum += $countones(fr_keep[i]);
      ue |= fr_user[i];
      if (fr_keep[i] == 8'h00) ke = 1;
      else if (i < n - 1) begin
        if (fr_keep[i] != 8'hff) ke = 1;
      end else begin
        contig = 0;
        for (int b = 1; b <= 8; b++) if (fr_keep[i] == 8'((1 << b) - 1)) contig = 1;
        if (!contig) ke = 1;
      end
    end
    bc = (sum > 65535) ? 16'hFFFF : 16'(sum);
    return {13'd0, ue, ke, (sum > MAXB), bc};
  endfunction

  // Monitor: every data write and status write is matched against what the bench queued.
  always @(negedge clk) begin
    if (reset) begin
      exp_data.delete();
      exp_fc = 16'd0;
    end else begin
      if (txdata_wrreq) begin
        checks++;
        assert (exp_data.size() > 0) else begin
          errors++;
          $error("FAIL data_unexpected observed=%0h expected=no_write", wr2_txdata_fifo);
        end
        if (exp_data.size() > 0) begin
          mon_d = exp_data.pop_front();
          chk("txdata", wr2_txdata_fifo, mon_d);
        end
      end
      if (txwbcnt_wrreq) begin
        stat_writes++;
        exp_fc = exp_fc + 16'd1;
        checks++;
        assert (exp_stat.size() > 0) else begin
          errors++;
          $error("FAIL status_unexpected observed=%0h expected=no_write", wr2_txwbcnt_fifo);
        end
        if (exp_stat.size() > 0) begin
          mon_s = exp_stat.pop_front();
          chk("status", wr2_txwbcnt_fifo, mon_s);
        end
        chk("frame_cnt", frame_cnt, exp_fc);
        chk("ovs_cleared_at_status", bcnt_more_than_max, 1'b0);
      end
    end
  end

  // Present one beat, hold it until accepted, then check the 1-cycle write latency.
  task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                            input logic u, output int waited);
    bit got;
    got = 0; waited = 0;
    s0.tdata = d; s0.tkeep = k; s0.tlast = l; s0.tuser = u; s0.tvalid = 1'b1;
    exp_data.push_back(d);
    while (!got) begin
      @(negedge clk);
      if (s0.tready) got = 1;
      else begin
        waited++;
        if (waited > BOUND) begin
          errors++;
          $display("FAIL tready_timeout observed=0 expected=1 errors=%0d", errors);
          $fatal(1, "stimulus stalled");
        end
      end
    end
    @(posedge clk); #1;
    s0.tvalid = 1'b0;
    chk("wrreq_latency", txdata_wrreq, 1'b1);
    chk("wrdata_latency", wr2_txdata_fifo, d);
  endtask

  task automatic gen_frame(input int n);
    int r;
    for (int i = 0; i < n; i++) begin
      fr_data[i] = {$urandom, $urandom};
      fr_user[i] = ($urandom_range(0, 15) == 0);
      if (i < n - 1) fr_keep[i] = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'hff;
      else begin
        r = $urandom_range(0, 9);
        if (r < 7) fr_keep[i] = 8'hff >> $urandom_range(0, 7);
        else       fr_keep[i] = 8'($urandom);
      end
    end
  endtask

  task automatic send_frame(input int n);
    int w;
    exp_stat.push_back(model_status(n));
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      txdata_wrusedw = 9'($urandom_range(0, 507));
      drive_beat(fr_data[i], fr_keep[i], (i == n - 1), fr_user[i], w);
    end
    txdata_wrusedw = 9'd0;
  endtask

  initial begin
    int          w;
    int          sw0;
    bit          seen;
    logic [127:0] d128;

    s0.tdata = '0; s0.tkeep = '0; s0.tvalid = 1'b0; s0.tlast = 1'b0; s0.tuser = 1'b0;
    s1.tdata = '0; s1.tkeep = '0; s1.tvalid = 1'b0; s1.tlast = 1'b0; s1.tuser = 1'b0;
    txdata_wrfull = 1'b1; txdata_wrusedw = 9'd0; txwbcnt_wrfull = 1'b0;
    d1_wrfull = 1'b0; d1_usedw = 9'd0; d1_statfull = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", axis_wr_state, 3'b001);
    chk("rst_tready", s0.tready, 1'b0);
    chk("rst_wrreq", txdata_wrreq, 1'b0);
    chk("rst_wrdata", wr2_txdata_fifo, 64'd0);
    chk("rst_status", wr2_txwbcnt_fifo, 32'd0);
    chk("rst_statreq", txwbcnt_wrreq, 1'b0);
    chk("rst_ovs", bcnt_more_than_max, 1'b0);
    chk("rst_frame_cnt", frame_cnt, 16'd0);
    reset = 1'b0;

    // IDLE holds while the data FIFO reports full
    repeat (3) @(posedge clk);
    #1;
    chk("idle_hold_on_full", axis_wr_state, 3'b001);
    txdata_wrfull = 1'b0;
    @(posedge clk); #1;
    chk("idle_to_data", axis_wr_state, 3'b010);

    // Three-beat frame ff/ff/0f -> 20 bytes
    exp_stat.push_back(32'h0000_0014);
    drive_beat(64'h0123_4567_89ab_cdef, 8'hff, 1'b0, 1'b0, w);
    drive_beat(64'hfedc_ba98_7654_3210, 8'hff, 1'b0, 1'b0, w);
    drive_beat(64'h0000_0000_a5a5_5a5a, 8'h0f, 1'b1, 1'b0, w);
    repeat (4) @(posedge clk);
    #1;
    chk("t1_frame_cnt", frame_cnt, 16'd1);

    // Short last beat 05 and tuser on beat 1: keep_err, tuser_err, 18 bytes
    exp_stat.push_back(32'h0006_0012);
    drive_beat(64'h1111_1111_1111_1111, 8'hff, 1'b0, 1'b1, w);
    drive_beat(64'h2222_2222_2222_2222, 8'hff, 1'b0, 1'b0, w);
    drive_beat(64'h3333_3333_3333_3333, 8'h05, 1'b1, 1'b0, w);

    // Nine full beats, limit 64: oversize on beat 9; first beat shows minimum spacing
    exp_stat.push_back(32'h0001_0048);
    for (int i = 0; i < 9; i++) begin
      drive_beat({32'hc0de_0000, 32'(i)}, 8'hff, (i == 8), 1'b0, w);
      if (i == 0) chk("min_spacing_bubbles", w, 2);
      chk($sformatf("t3_ovs_beat%0d", i + 1), bcnt_more_than_max, (i == 8));
    end

    // Almost-full back-pressure mid-frame
    exp_stat.push_back(32'h0000_0030);
    drive_beat(64'hd0d0_0000_0000_0000, 8'hff, 1'b0, 1'b0, w);
    drive_beat(64'hd0d0_0000_0000_0001, 8'hff, 1'b0, 1'b0, w);
    txdata_wrusedw = 9'd508;
    drive_beat(64'hd0d0_0000_0000_0002, 8'hff, 1'b0, 1'b0, w);
    chk("t2_lag_beat_taken", w, 0);
    repeat (4) begin
      @(negedge clk);
      chk("t2_tready_low", s0.tready, 1'b0);
    end
    @(posedge clk); #1;
    txdata_wrusedw = 9'd507;
    drive_beat(64'hd0d0_0000_0000_0003, 8'hff, 1'b0, 1'b0, w);
    chk("t2_tready_return", w, 1);
    txdata_wrusedw = 9'd0;
    drive_beat(64'hd0d0_0000_0000_0004, 8'hff, 1'b0, 1'b0, w);
    drive_beat(64'hd0d0_0000_0000_0005, 8'hff, 1'b1, 1'b0, w);

    // Status FIFO full for 5 cycles at frame end
    exp_stat.push_back(32'h0000_000e);
    drive_beat(64'he0e0_e0e0_0000_0000, 8'hff, 1'b0, 1'b0, w);
    txwbcnt_wrfull = 1'b1;
    drive_beat(64'he0e0_e0e0_0000_0001, 8'h3f, 1'b1, 1'b0, w);
    sw0 = stat_writes;
    repeat (5) begin
      @(negedge clk);
      chk("t5_state_stat", axis_wr_state, 3'b100);
      chk("t5_tready_low", s0.tready, 1'b0);
      chk("t5_no_statreq", txwbcnt_wrreq, 1'b0);
    end
    @(posedge clk); #1;
    txwbcnt_wrfull = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("t5_one_status_write", stat_writes - sw0, 1);

    // Random frames against the reference model
    for (int f = 0; f < 30; f++) begin
      int n;
      n = $urandom_range(1, 10);
      gen_frame(n);
      send_frame(n);
    end
    repeat (8) @(posedge clk);
    #1;

    // Reset in the middle of a frame
    drive_beat(64'hbad0_0000_0000_0000, 8'hff, 1'b0, 1'b0, w);
    drive_beat(64'hbad0_0000_0000_0001, 8'hff, 1'b0, 1'b0, w);
    reset = 1'b1;
    #1;
    chk("midrst_state", axis_wr_state, 3'b001);
    chk("midrst_tready", s0.tready, 1'b0);
    chk("midrst_wrreq", txdata_wrreq, 1'b0);
    chk("midrst_wrdata", wr2_txdata_fifo, 64'd0);
    chk("midrst_statreq", txwbcnt_wrreq, 1'b0);
    chk("midrst_status", wr2_txwbcnt_fifo, 32'd0);
    chk("midrst_frame_cnt", frame_cnt, 16'd0);
    chk("midrst_ovs", bcnt_more_than_max, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    sw0 = stat_writes;
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_no_status", stat_writes - sw0, 0);
    chk("midrst_back_in_data", axis_wr_state, 3'b010);

    // 128-bit instance: single beat, tkeep 00ff -> 8 bytes
    d128 = {$urandom, $urandom, $urandom, $urandom};
    s1.tdata = d128; s1.tkeep = 16'h00ff; s1.tlast = 1'b1; s1.tuser = 1'b0; s1.tvalid = 1'b1;
    seen = 0; w = 0;
    while (!seen && w < BOUND) begin
      @(negedge clk);
      if (s1.tready) seen = 1;
      else w++;
    end
    chk("w128_accepted", seen, 1'b1);
    @(posedge clk); #1;
    s1.tvalid = 1'b0;
    chk("w128_wrreq", d1_wrreq, 1'b1);
    chk("w128_wrdata", d1_wdata, d128);
    seen = 0; w = 0;
    while (!seen && w < 20) begin
      @(negedge clk);
      if (d1_statreq) seen = 1;
      else w++;
    end
    chk("w128_status_seen", seen, 1'b1);
    chk("w128_status", d1_stat, 32'h0000_0008);
    chk("w128_frame_cnt", d1_fc, 16'd1);

    chk("data_queue_drained", exp_data.size(), 0);
    chk("status_queue_drained", exp_stat.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axis2fib_txctrl_gen.md
Name: axis2fib_txctrl_gen

Overview:
Parametrised successor to the single-width AXI-Stream TX control block. It accepts frames from an AXI-Stream master of configurable width and writes data beats into the bridge TX data FIFO. After each frame it writes a status word into the TX byte-count FIFO: byte count plus error flags. Unlike the previous generation, it streams back-to-back frames without waiting for the data FIFO to drain, and it applies almost-full back-pressure.

Parameters:
DATA_WIDTH, 64, stream/FIFO data width; 64, 128 or 256.
KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
DATA_PTR, 8, data FIFO usedw width minus 1.
DATA_DEPTH, 512, data FIFO depth in entries.
AFULL_MARGIN, 4, free entries required to hold tready high; must be >= 2.
BCNT_WIDTH, 32, status word width; must be >= 19.
MAX_FRAME_BYTES, 1518, oversize threshold.

Ports:
clk  in  1  single clock; all logic rising edge
reset  in  1  asynchronous, active-high reset
s_axis_tdata  in  DATA_WIDTH  frame data
s_axis_tkeep  in  KEEP_WIDTH  byte enables, bit0 = byte0
s_axis_tvalid  in  1  beat valid
s_axis_tlast  in  1  last beat of frame
s_axis_tuser  in  1  master error mark
s_axis_tready  out  1  slave ready (registered)
wr2_txdata_fifo  out  DATA_WIDTH  data FIFO write data
txdata_wrreq  out  1  data FIFO write strobe
txdata_wrfull  in  1  data FIFO full
txdata_wrusedw  in  DATA_PTR+1  data FIFO fill level
wr2_txwbcnt_fifo  out  BCNT_WIDTH  status word
txwbcnt_wrreq  out  1  status FIFO write strobe
txwbcnt_wrfull  in  1  status FIFO full
bcnt_more_than_max  out  1  sticky oversize indication for the current frame
frame_cnt  out  16  count of status words written; wraps
axis_wr_state  out  3  one-hot state (debug)

Behaviour:
- Reset (async assert, sync release):
  - all outputs 0; axis_wr_state = IDLE (3'b001).
  - internal bcnt and flags cleared.
  - Reset mid-frame discards the partial frame; no status is written.
  - The data FIFO is not flushed by this block.
- States, one-hot: IDLE=3'b001, DATA=3'b010, STAT=3'b100.
  - IDLE -> DATA when !txdata_wrfull. Guards against FIFO IPs that hold full high in reset.
  - DATA -> STAT on an accepted beat with s_axis_tlast = 1.
  - STAT -> DATA the cycle after the status write.
- space_ok = !txdata_wrfull && (DATA_DEPTH - txdata_wrusedw) > AFULL_MARGIN; compute with DATA_PTR+2-bit unsigned arithmetic.
- s_axis_tready, registered:
  - next value = 1 in DATA when space_ok and no tlast is accepted this cycle; otherwise 0.
  - Always 0 in IDLE and STAT.
  - The one-cycle lag is absorbed by AFULL_MARGIN.
- Accept = s_axis_tvalid && s_axis_tready. A beat with tvalid while tready = 0 is held by the master and never lost.
- Data path, 1-cycle latency:
  - an accept in cycle N gives txdata_wrreq = 1 in cycle N+1, with wr2_txdata_fifo = tdata captured at N.
  - txdata_wrreq is 0 otherwise.
  - Every beat is written, including error and oversize frames; dropping is downstream's decision.
- Byte count:
  - bcnt += popcount(tkeep) per accepted beat; 16-bit, saturating at 16'hFFFF.
  - Cleared on entry to DATA from STAT or IDLE.
- keep_err is set, sticky per frame, for any of:
  - tkeep == 0;
  - non-last beat with tkeep != all-ones;
  - last beat with tkeep not of the form 2^k-1 (non-contiguous).
  - The popcount is still added.
- tuser_err: OR of s_axis_tuser over all accepted beats of the frame.
- oversize: set when bcnt + popcount(current beat) > MAX_FRAME_BYTES.
  - bcnt_more_than_max equals the oversize flag; it is cleared in the cycle the status is written.
- Status word, written in STAT:
  - [15:0] = bcnt
  - [16] = oversize
  - [17] = keep_err
  - [18] = tuser_err
  - upper bits = 0
- STAT handshake:
  - while txwbcnt_wrfull = 1, hold in STAT with txwbcnt_wrreq = 0 and tready = 0.
  - otherwise pulse txwbcnt_wrreq for exactly one cycle, increment frame_cnt, and clear the flags.
- Single-beat frame (tvalid+tlast on the first beat) is legal: DATA -> STAT -> DATA, 1 status write.
- Minimum frame spacing: 2 bubble cycles (tready-low cycles) between the tlast accept and the next accept.

Test Plan:
1. DATA_WIDTH=64; frame of 3 beats, tkeep ff, ff, 0f, FIFOs empty -> 3 txdata_wrreq pulses with matching data (1-cycle latency); one status write = 32'h0000_0014; frame_cnt = 1.
2. txdata_wrusedw = DATA_DEPTH-4 (AFULL_MARGIN=4) mid-frame -> tready low within 1 cycle; no beats lost; tready returns when usedw drops to DATA_DEPTH-5.
3. MAX_FRAME_BYTES=64; 9 full 8-byte beats -> bcnt_more_than_max rises on beat 9; status = 32'h0001_0048; all 9 beats written.
4. Last beat tkeep=8'h05 plus tuser=1 on beat 1 -> status bits 17 and 18 set; byte count = 8*(n-1)+2.
5. txwbcnt_wrfull held 5 cycles at frame end -> state stays STAT; tready stays 0; exactly one txwbcnt_wrreq after full drops.
6. reset pulse mid-frame -> all outputs 0 immediately; state IDLE; no status write. DATA_WIDTH=128 run: one beat tkeep 16'h00ff -> status = 32'h0000_0008.
